// File: rtl/proc_bus_req_queue_pkg.sv
// Shared bus types for the processor-side request queue: widths, command record, FSM states.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    typedef logic [BUS_ADDR_W-1:0] BusAddr_t;
    typedef logic [BUS_DATA_W-1:0] BusData_t;

    typedef struct packed {
        logic     read;
        BusAddr_t addr;
        BusData_t wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        RESP    = 3'd4
    } ReqQState_t;

endpackage

// File: rtl/proc_bus_req_queue_if.sv
// Core-side command/response channels and the bus-master request handshake of the request queue.
interface proc_bus_req_queue_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // Handshakes: cmd and rsp transfer on a cycle where valid && ready; a raised valid and its
    // payload stay put until that cycle. mst_access holds until mst_start; the mst_* payload
    // stays stable from issue until the matching rd/wr done pulse.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_read;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_read;
    logic [DATA_W-1:0] rsp_data;
    logic              mst_access;
    logic              mst_do_read;
    logic [ADDR_W-1:0] mst_addr;
    logic [DATA_W-1:0] mst_wdata;
    logic              mst_wdata_rdy;
    logic              mst_start;
    logic              mst_rd_done;
    logic [DATA_W-1:0] mst_rd_data;
    logic              mst_wr_done;

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready,
               mst_start, mst_rd_done, mst_rd_data, mst_wr_done,
        output cmd_ready, rsp_valid, rsp_read, rsp_data,
               mst_access, mst_do_read, mst_addr, mst_wdata, mst_wdata_rdy
    );

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready,
               mst_start, mst_rd_done, mst_rd_data, mst_wr_done,
        input  cmd_ready, rsp_valid, rsp_read, rsp_data,
               mst_access, mst_do_read, mst_addr, mst_wdata, mst_wdata_rdy
    );

endinterface

// File: rtl/proc_bus_req_queue_fifo.sv
// Command FIFO for the request queue: power-of-two depth, wrapping pointers, occupancy count.
module req_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   push,
    input  logic [W-1:0]           pushData,
    input  logic                   pop,
    output logic [W-1:0]           popData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/proc_bus_req_queue.sv
// Processor bus request queue: buffers core commands, issues one bus transaction at a time
// and returns exactly one response per command.
module proc_bus_req_queue
    import bus_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int WDATA_DELAY = 0
) (
    input  logic                   clock,
    input  logic                   resetN,
    proc_bus_req_queue_if.slave    bus,
    output ReqQState_t             dbgState,
    output logic [$clog2(DEPTH):0] dbgCount
);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = (WDATA_DELAY < 1) ? 1 : $clog2(WDATA_DELAY + 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(WDATA_DELAY);

    ReqQState_t        state;
    ReqQState_t        nextState;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ENTRY_W-1:0] headEntry;
    logic              curRead;
    logic [ADDR_W-1:0] curAddr;
    logic [DATA_W-1:0] curWdata;
    logic [CNT_W-1:0]  delayCnt;
    logic              rspRead;
    logic [DATA_W-1:0] rspData;
    logic              mstAccess;
    logic              wdataRdy;
    logic              rspValid;

    // Pops happen only in IDLE, so a response held in RESP stalls the queue head.
    assign push = bus.cmd_valid && !full;
    assign pop  = (state == IDLE) && !empty;

    req_cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clock    (clock),
        .resetN   (resetN),
        .push     (push),
        .pushData ({bus.cmd_read, bus.cmd_addr, bus.cmd_wdata}),
        .pop      (pop),
        .popData  (headEntry),
        .full     (full),
        .empty    (empty),
        .count    (dbgCount)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!empty)          nextState = ISSUE;
            ISSUE:   if (bus.mst_start)   nextState = curRead ? WAIT_RD : WAIT_WR;
            WAIT_RD: if (bus.mst_rd_done) nextState = RESP;
            WAIT_WR: if (bus.mst_wr_done) nextState = RESP;
            RESP:    if (bus.rsp_ready)   nextState = IDLE;
            default:                      nextState = IDLE;
        endcase
    end

    always_comb begin
        mstAccess = 1'b0;
        wdataRdy  = 1'b0;
        rspValid  = 1'b0;
        case (state)
            ISSUE:   mstAccess = 1'b1;
            WAIT_WR: wdataRdy  = (delayCnt == '0);
            RESP:    rspValid  = 1'b1;
            default: ;
        endcase
    end

    // The current command stays registered until the next pop, keeping mst_* stable through completion.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            curRead  <= 1'b0;
            curAddr  <= '0;
            curWdata <= '0;
            delayCnt <= '0;
            rspRead  <= 1'b0;
            rspData  <= '0;
        end else begin
            if (pop) {curRead, curAddr, curWdata} <= headEntry;
            if (state == ISSUE && bus.mst_start && !curRead)
                delayCnt <= DELAY_LOAD;
            else if (state == WAIT_WR && delayCnt != '0)
                delayCnt <= delayCnt - 1'b1;
            if (state == WAIT_RD && bus.mst_rd_done) begin
                rspRead <= 1'b1;
                rspData <= bus.mst_rd_data;
            end
            if (state == WAIT_WR && bus.mst_wr_done) begin
                rspRead <= 1'b0;
                rspData <= '0;
            end
        end
    end

    assign bus.cmd_ready     = !full;
    assign bus.mst_access    = mstAccess;
    assign bus.mst_do_read   = curRead;
    assign bus.mst_addr      = curAddr;
    assign bus.mst_wdata     = curWdata;
    assign bus.mst_wdata_rdy = wdataRdy;
    assign bus.rsp_valid     = rspValid;
    assign bus.rsp_read      = rspRead;
    assign bus.rsp_data      = rspData;
    assign dbgState          = state;

endmodule
